button_debounce_multi: RTL

Parametrised multi-channel button front end: synchronises N asynchronous button inputs, debounces each channel with a per-channel stability counter, and emits a clean level plus single-cycle press, release and long-press pulses. Successor to the single-channel button synchroniser; sits between board-level button pins and any control FSM that consumes user input. All channels are fully independent.

---
 rtl/button_debounce_multi_if.sv | 43 ++++
 rtl/button_debounce_multi.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_multi_if.sv
// ---------------------------------------------------------------------------
// button_debounce_multi_if
//
// Bundle of per-channel button signals between the board pins and the
// debounce block.
//
//   btn_in      : raw asynchronous button pins (pin side drives)
//   btn_level   : debounced level, 1 = pressed
//   btn_press   : single-cycle pulse on an accepted press
//   btn_release : single-cycle pulse on an accepted release
//   btn_long    : single-cycle pulse once per press after the long-hold time
//
// Modports:
//   master : pin / consumer side (drives btn_in, observes the outputs)
//   slave  : debounce block side (observes btn_in, drives the outputs)
// ---------------------------------------------------------------------------
interface button_debounce_multi_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] btn_level;
  logic [CHANNELS-1:0] btn_press;
  logic [CHANNELS-1:0] btn_release;
  logic [CHANNELS-1:0] btn_long;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );

endinterface

// File: rtl/button_debounce_multi.sv
// ---------------------------------------------------------------------------
// button_debounce_multi
//
// Multi-channel button front end. Each channel is fully independent:
//   1. SYNC_STAGES-deep synchroniser on the raw pin (no logic between flops),
//      polarity normalised after the last stage so 1 always means pressed.
//   2. Stability counter: a new synchronised value must be seen for
//      DEBOUNCE_CYCLES consecutive cycles before the level is accepted; any
//      matching sample in between throws the partial count away.
//   3. Hold counter: once pressed, counts up to LONG_CYCLES and emits one
//      long-press pulse when it gets there (LONG_CYCLES = 0 removes it).
//
// Parameters:
//   CHANNELS        : number of button channels (>= 1)
//   SYNC_STAGES     : synchroniser flops per channel (>= 2)
//   DEBOUNCE_CYCLES : cycles a new value must hold before acceptance (>= 1)
//   LONG_CYCLES     : held cycles before btn_long, 0 disables long-press
//   ACTIVE_LOW      : 1 = a pressed button pulls its pin low
//
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset (release is synchronised upstream)
//   bus : button_debounce_multi_if slave modport
//         (btn_in in; btn_level / btn_press / btn_release / btn_long out,
//          all outputs registered)
// ---------------------------------------------------------------------------
module button_debounce_multi #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  button_debounce_multi_if.slave  bus
);

  localparam int              DC_W     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DC_W-1:0] DC_LAST  = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DC_W-1:0] DC_ONE   = DC_W'(1'b1);
  localparam logic [DC_W-1:0] DC_ZERO  = DC_W'(1'b0);
  // Pin level of a released button; also the synchroniser reset value.
  localparam logic            PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // -------------------------------------------------------------------------
  // Synchroniser
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_d [CHANNELS];
  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [CHANNELS-1:0]    samp_s;

  // Shift each raw pin into its chain and normalise the last stage to 1 = pressed.
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], bus.btn_in[ch]};
      samp_s[ch] = sync_q[ch][SYNC_STAGES-1] ^ PIN_IDLE;
    end
  end

  // Synchroniser flops; reset to the idle pin level so reset release never reads as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        sync_q[ch] <= {SYNC_STAGES{PIN_IDLE}};
      end
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        sync_q[ch] <= sync_d[ch];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Debounce: level, stability counter, press/release pulses
  // -------------------------------------------------------------------------
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] level_q;
  logic [DC_W-1:0]     dc_d [CHANNELS];
  logic [DC_W-1:0]     dc_q [CHANNELS];
  logic [CHANNELS-1:0] press_d;
  logic [CHANNELS-1:0] press_q;
  logic [CHANNELS-1:0] release_d;
  logic [CHANNELS-1:0] release_q;
  // High on the edge a new level is accepted (press or release).
  logic [CHANNELS-1:0] accept_s;

  // Per-channel stability counting; a differing run that breaks early gets no partial credit.
  always_comb begin
    level_d   = level_q;
    press_d   = {CHANNELS{1'b0}};
    release_d = {CHANNELS{1'b0}};
    accept_s  = {CHANNELS{1'b0}};
    for (int ch = 0; ch < CHANNELS; ch++) begin
      dc_d[ch] = dc_q[ch];
      if (samp_s[ch] == level_q[ch]) begin
        dc_d[ch] = DC_ZERO;
      end else if (dc_q[ch] == DC_LAST) begin
        level_d[ch]   = samp_s[ch];
        dc_d[ch]      = DC_ZERO;
        press_d[ch]   = samp_s[ch];
        release_d[ch] = ~samp_s[ch];
        accept_s[ch]  = 1'b1;
      end else begin
        dc_d[ch] = dc_q[ch] + DC_ONE;
      end
    end
  end

  // Debounce state and press/release pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= {CHANNELS{1'b0}};
      press_q   <= {CHANNELS{1'b0}};
      release_q <= {CHANNELS{1'b0}};
      for (int ch = 0; ch < CHANNELS; ch++) begin
        dc_q[ch] <= DC_ZERO;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        dc_q[ch] <= dc_d[ch];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Long-press detection
  // -------------------------------------------------------------------------
  logic [CHANNELS-1:0] long_s;

  if (LONG_CYCLES > 0) begin : g_long
    localparam int              HC_W    = $clog2(LONG_CYCLES) + 1;
    localparam logic [HC_W-1:0] HC_MAX  = HC_W'(LONG_CYCLES);
    localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1'b1);
    localparam logic [HC_W-1:0] HC_ZERO = HC_W'(1'b0);

    logic [HC_W-1:0]     hc_d [CHANNELS];
    logic [HC_W-1:0]     hc_q [CHANNELS];
    logic [CHANNELS-1:0] long_d;
    logic [CHANNELS-1:0] long_q;

    // Hold counter saturates at HC_MAX so the pulse fires once per press. Any
    // accepted transition clears it: that keeps the press edge at zero and
    // stops a release edge from coinciding with a long pulse.
    always_comb begin
      long_d = {CHANNELS{1'b0}};
      for (int ch = 0; ch < CHANNELS; ch++) begin
        hc_d[ch] = hc_q[ch];
        if (accept_s[ch] || !level_q[ch]) begin
          hc_d[ch] = HC_ZERO;
        end else if (hc_q[ch] != HC_MAX) begin
          hc_d[ch]   = hc_q[ch] + HC_ONE;
          long_d[ch] = (hc_q[ch] == (HC_MAX - HC_ONE));
        end else begin
          hc_d[ch] = hc_q[ch];
        end
      end
    end

    // Hold counters and long-press pulse register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        long_q <= {CHANNELS{1'b0}};
        for (int ch = 0; ch < CHANNELS; ch++) begin
          hc_q[ch] <= HC_ZERO;
        end
      end else begin
        long_q <= long_d;
        for (int ch = 0; ch < CHANNELS; ch++) begin
          hc_q[ch] <= hc_d[ch];
        end
      end
    end

    assign long_s = long_q;
  end else begin : g_no_long
    assign long_s = {CHANNELS{1'b0}};
  end

  // -------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // -------------------------------------------------------------------------
  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_long    = long_s;

endmodule
